// File: rtl/mul8_seq_ctrl_if.sv
// mul8_seq_ctrl_if
//   Groups every handshake and partial-product signal of the 8x8 sequencer.
//   clk and rst_n stay plain module ports.
//
//   Operand side : in_valid, in_ready, in_a[7:0], in_b[7:0], in_skip[3:0]
//   PP unit side : pp_en, pp_sel[1:0], pp_a[3:0], pp_b[3:0], pp_prod[7:0]
//   Result side  : out_valid, out_ready, out_prod[15:0]
//
//   slave  : the sequencer itself
//   master : the environment (operand producer, PP unit, result consumer)
interface mul8_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [3:0]  in_skip;
  logic        pp_en;
  logic [1:0]  pp_sel;
  logic [3:0]  pp_a;
  logic [3:0]  pp_b;
  logic [7:0]  pp_prod;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_prod;

  modport slave (
    input  in_valid, in_a, in_b, in_skip, pp_prod, out_ready,
    output in_ready, pp_en, pp_sel, pp_a, pp_b, out_valid, out_prod
  );

  modport master (
    output in_valid, in_a, in_b, in_skip, pp_prod, out_ready,
    input  in_ready, pp_en, pp_sel, pp_a, pp_b, out_valid, out_prod
  );
endinterface

// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl
//   Time-multiplexed sequencer for the 8x8 approximate multiplier. An accepted
//   operand pair is split into nibbles and issued to one shared 4x4 partial-
//   product unit in the order LL, LH, HL, HH (skipped positions are never
//   visited). Partial products are shifted and summed into a 17-bit
//   accumulator; the 16-bit result saturates to 16'hFFFF on overflow.
//
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mul8_seq_ctrl_if.slave (operand handshake, PP unit, result handshake)
module mul8_seq_ctrl (
  input  logic           clk,
  input  logic           rst_n,
  mul8_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_LL, S_LH, S_HL, S_HH, S_DONE} state_t;

  state_t      r_state;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [3:0]  r_skip;
  logic [16:0] r_acc;
  logic        r_ppEn;
  logic [1:0]  r_ppSel;
  logic [3:0]  r_ppA;
  logic [3:0]  r_ppB;
  logic        r_outValid;
  logic [15:0] r_outProd;

  state_t      w_nextState;
  logic        w_inReady;
  logic        w_accept;
  logic        w_isIssue;
  logic        w_enterDone;
  logic [3:0]  w_enIn;
  logic [3:0]  w_enReg;
  logic [16:0] w_ppShifted;
  logic [16:0] w_accSum;
  logic [15:0] w_doneValue;
  logic [7:0]  w_opA;
  logic [7:0]  w_opB;
  logic        w_ppEnNext;
  logic [1:0]  w_ppSelNext;
  logic [3:0]  w_ppANext;
  logic [3:0]  w_ppBNext;

  // en[0]=LL .. en[3]=HH; returns the earliest enabled issue state
  function automatic state_t firstIssue(input logic [3:0] en);
    if (en[0]) return S_LL;
    if (en[1]) return S_LH;
    if (en[2]) return S_HL;
    if (en[3]) return S_HH;
    return S_DONE;
  endfunction

  // Skip bit i belongs to pp_sel i (0=HH .. 3=LL), so reverse it into issue order
  assign w_enIn  = {~bus.in_skip[0], ~bus.in_skip[1], ~bus.in_skip[2], ~bus.in_skip[3]};
  assign w_enReg = {~r_skip[0], ~r_skip[1], ~r_skip[2], ~r_skip[3]};

  // DONE can hand off directly to a new operation when the result is consumed
  assign w_inReady = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
  assign w_accept  = bus.in_valid && w_inReady;

  // Next state and the weighted partial product added at the closing edge
  always_comb begin
    w_nextState = r_state;
    w_ppShifted = '0;
    w_isIssue   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) w_nextState = firstIssue(w_enIn);
      end
      S_LL: begin
        w_isIssue   = 1'b1;
        w_ppShifted = {9'd0, bus.pp_prod};
        w_nextState = firstIssue(w_enReg & 4'b1110);
      end
      S_LH: begin
        w_isIssue   = 1'b1;
        w_ppShifted = {5'd0, bus.pp_prod, 4'd0};
        w_nextState = firstIssue(w_enReg & 4'b1100);
      end
      S_HL: begin
        w_isIssue   = 1'b1;
        w_ppShifted = {5'd0, bus.pp_prod, 4'd0};
        w_nextState = firstIssue(w_enReg & 4'b1000);
      end
      S_HH: begin
        w_isIssue   = 1'b1;
        w_ppShifted = {1'b0, bus.pp_prod, 8'd0};
        w_nextState = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) w_nextState = bus.in_valid ? firstIssue(w_enIn) : S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
    w_accSum = r_acc + w_ppShifted;
    // A fully skipped op re-enters DONE straight from accept with a zero result
    w_enterDone = (w_nextState == S_DONE) && ((r_state != S_DONE) || w_accept);
    w_doneValue = w_accept ? 16'h0000 : (w_accSum[16] ? 16'hFFFF : w_accSum[15:0]);
  end

  // PP outputs are registered from the state being entered, so they never
  // follow in_* combinationally even though a fresh operand pair feeds them
  always_comb begin
    w_opA       = w_accept ? bus.in_a : r_a;
    w_opB       = w_accept ? bus.in_b : r_b;
    w_ppEnNext  = 1'b0;
    w_ppSelNext = 2'd0;
    w_ppANext   = 4'd0;
    w_ppBNext   = 4'd0;
    case (w_nextState)
      S_LL: begin
        w_ppEnNext = 1'b1; w_ppSelNext = 2'd3; w_ppANext = w_opA[3:0]; w_ppBNext = w_opB[3:0];
      end
      S_LH: begin
        w_ppEnNext = 1'b1; w_ppSelNext = 2'd2; w_ppANext = w_opA[3:0]; w_ppBNext = w_opB[7:4];
      end
      S_HL: begin
        w_ppEnNext = 1'b1; w_ppSelNext = 2'd1; w_ppANext = w_opA[7:4]; w_ppBNext = w_opB[3:0];
      end
      S_HH: begin
        w_ppEnNext = 1'b1; w_ppSelNext = 2'd0; w_ppANext = w_opA[7:4]; w_ppBNext = w_opB[7:4];
      end
      default: ;
    endcase
  end

  // State, operand latches, accumulator and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_skip     <= '0;
      r_acc      <= '0;
      r_ppEn     <= 1'b0;
      r_ppSel    <= '0;
      r_ppA      <= '0;
      r_ppB      <= '0;
      r_outValid <= 1'b0;
      r_outProd  <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_a    <= bus.in_a;
        r_b    <= bus.in_b;
        r_skip <= bus.in_skip;
        r_acc  <= '0;
      end else if (w_isIssue) begin
        r_acc <= w_accSum;
      end
      if (w_enterDone) r_outProd <= w_doneValue;
      r_outValid <= (w_nextState == S_DONE);
      r_ppEn     <= w_ppEnNext;
      r_ppSel    <= w_ppSelNext;
      r_ppA      <= w_ppANext;
      r_ppB      <= w_ppBNext;
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.pp_en     = r_ppEn;
  assign bus.pp_sel    = r_ppSel;
  assign bus.pp_a      = r_ppA;
  assign bus.pp_b      = r_ppB;
  assign bus.out_valid = r_outValid;
  assign bus.out_prod  = r_outProd;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// tb_mul8_seq_ctrl
//   Scoreboard bench for mul8_seq_ctrl. The driver pushes the expected result
//   of every accepted operation; a negedge monitor checks the PP issue stream,
//   handshake rules and each presented result against that queue.
module tb_mul8_seq_ctrl;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  skip;
    logic [15:0] prod;
    int          acceptEdge;
    int          nIssue;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic forceFF = 1'b0;
  logic randomReady = 1'b0;
  logic randReady = 1'b1;
  logic fixedReady = 1'b1;

  int compared = 0;
  int mismatched = 0;
  int edgeCount = 0;
  int ppIdx = 0;
  logic prevValid = 1'b0;
  logic prevHandshake = 1'b0;
  logic [15:0] curProd = '0;
  logic [15:0] lastProd = '0;
  exp_t q[$];

  mul8_seq_ctrl_if bus();

  mul8_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Exact 4x4 partial-product unit, optionally stuck at 8'hFF
  always_comb bus.pp_prod = forceFF ? 8'hFF : ({4'd0, bus.pp_a} * {4'd0, bus.pp_b});

  assign bus.out_ready = randomReady ? randReady : fixedReady;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  always @(posedge clk) begin
    #1;
    randReady = ($urandom_range(0, 3) != 0);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic failNow(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s (t=%0t)", name, $time);
  endtask

  // Product as the position-weighted sum of nibble products, saturated to 16 bits
  function automatic logic [15:0] refProduct(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] skip, input logic ff);
    int unsigned x[4];
    int unsigned y[4];
    int unsigned w[4];
    int unsigned total;
    x = '{int'(a[7:4]), int'(a[7:4]), int'(a[3:0]), int'(a[3:0])};
    y = '{int'(b[7:4]), int'(b[3:0]), int'(b[7:4]), int'(b[3:0])};
    w = '{256, 16, 16, 1};
    total = 0;
    for (int k = 0; k < 4; k++)
      if (!skip[k]) total += (ff ? 255 : x[k] * y[k]) * w[k];
    if (total > 65535) return 16'hFFFF;
    return total[15:0];
  endfunction

  // idx-th issued pp_sel: order is LL(3), LH(2), HL(1), HH(0) minus skipped ones
  function automatic logic [31:0] expectedSel(input logic [3:0] skip, input int idx);
    int n;
    n = 0;
    for (int k = 3; k >= 0; k--) begin
      if (!skip[k]) begin
        if (n == idx) return k;
        n++;
      end
    end
    return 32'hFF;
  endfunction

  function automatic int countIssues(input logic [3:0] skip);
    int n;
    n = 0;
    for (int k = 0; k < 4; k++) if (!skip[k]) n++;
    return n;
  endfunction

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [3:0] skip);
    exp_t e;
    bit accepted;
    accepted = 0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_skip  = skip;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 60 && !accepted; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.a = a; e.b = b; e.skip = skip;
        e.prod = refProduct(a, b, skip, forceFF);
        e.acceptEdge = edgeCount + 1;
        e.nIssue = countIssues(skip);
        q.push_back(e);
        accepted = 1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!accepted) failNow("accept_timeout");
  endtask

  task automatic waitDrain();
    bit done;
    done = 0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (q.size() == 0) done = 1;
    end
    @(posedge clk); #1;
    if (!done) failNow("drain_timeout");
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, bus.in_ready, 1);
    checkOutput({tag, "_out_valid"}, bus.out_valid, 0);
    checkOutput({tag, "_out_prod"}, bus.out_prod, 0);
    checkOutput({tag, "_pp_en"}, bus.pp_en, 0);
    checkOutput({tag, "_pp_sel"}, bus.pp_sel, 0);
    checkOutput({tag, "_pp_a"}, bus.pp_a, 0);
    checkOutput({tag, "_pp_b"}, bus.pp_b, 0);
  endtask

  // Monitor: handshake rules, issue stream and result scoreboard
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] sel;
    if (!rst_n) begin
      q.delete();
      ppIdx = 0;
      prevValid = 1'b0;
      prevHandshake = 1'b0;
    end else begin
      checkOutput("in_ready", bus.in_ready, bus.out_valid ? bus.out_ready : !bus.pp_en);
      if (bus.pp_en) begin
        if (q.size() == 0) begin
          failNow("pp_en_without_op");
        end else begin
          e = q[0];
          sel = expectedSel(e.skip, ppIdx);
          checkOutput("pp_sel", bus.pp_sel, sel);
          checkOutput("pp_a", bus.pp_a, sel[1] ? e.a[3:0] : e.a[7:4]);
          checkOutput("pp_b", bus.pp_b, sel[0] ? e.b[3:0] : e.b[7:4]);
          ppIdx++;
        end
      end else begin
        checkOutput("pp_idle", {bus.pp_sel, bus.pp_a, bus.pp_b}, 0);
      end
      if (bus.out_valid && (!prevValid || prevHandshake)) begin
        if (q.size() == 0) begin
          failNow("unexpected_result");
        end else begin
          e = q.pop_front();
          checkOutput("out_prod", bus.out_prod, e.prod);
          checkOutput("latency", edgeCount - e.acceptEdge, e.nIssue);
          checkOutput("pp_count", ppIdx, e.nIssue);
          ppIdx = 0;
          curProd = e.prod;
          lastProd = bus.out_prod;
        end
      end else if (bus.out_valid) begin
        checkOutput("hold_out_prod", bus.out_prod, curProd);
      end
      prevValid = bus.out_valid;
      prevHandshake = bus.out_valid && bus.out_ready;
    end
  end

  // Directed cases followed by randomized traffic with random backpressure
  initial begin
    bit found;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_skip  = '0;
    #2;
    checkResetValues("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    applyStimulus(8'hAB, 8'hCD, 4'h0);
    waitDrain();
    checkOutput("full_88EF", lastProd, 16'h88EF);

    applyStimulus(8'hAB, 8'hCD, 4'b1000);
    waitDrain();
    checkOutput("skipLL_8860", lastProd, 16'h8860);

    applyStimulus(8'($urandom), 8'($urandom), 4'hF);
    waitDrain();
    checkOutput("skipAll_0000", lastProd, 16'h0000);

    forceFF = 1'b1;
    applyStimulus(8'hFF, 8'hFF, 4'h0);
    waitDrain();
    forceFF = 1'b0;
    checkOutput("saturate_FFFF", lastProd, 16'hFFFF);

    fixedReady = 1'b0;
    applyStimulus(8'h5A, 8'h3C, 4'h0);
    found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clk);
      if (bus.out_valid) found = 1;
    end
    if (!found) failNow("bp_valid_timeout");
    for (int t = 0; t < 3; t++) begin
      if (t > 0) @(negedge clk);
      checkOutput("bp_out_valid", bus.out_valid, 1);
      checkOutput("bp_in_ready", bus.in_ready, 0);
    end
    @(posedge clk); #1;
    fixedReady = 1'b1;
    applyStimulus(8'h12, 8'h34, 4'h0);
    waitDrain();
    checkOutput("handoff_03A8", lastProd, 16'h03A8);

    applyStimulus(8'hAB, 8'hCD, 4'h0);
    found = 0;
    for (int t = 0; t < 10 && !found; t++) begin
      if (bus.pp_en && bus.pp_sel == 2'd2) found = 1;
      else begin @(posedge clk); #1; end
    end
    if (!found) failNow("lh_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("midop");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(8'h02, 8'h03, 4'h0);
    waitDrain();
    checkOutput("post_reset_0006", lastProd, 16'h0006);

    randomReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    @(posedge clk); #2;
    randomReady = 1'b0;
    fixedReady = 1'b1;
    waitDrain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
